// File: rtl/xillybus_pkg.sv
// Shared definitions for the Xillybus read-stream multiplexer: trailer layout and FSM states.
package xillybus_pkg;

    localparam logic [7:0] TRL_MARK      = 8'hCE;
    localparam int         TRL_MARK_LSB  = 24;
    localparam int         TRL_TRUNC_BIT = 23;
    localparam int         TRL_CH_LSB    = 16;
    localparam int         TRL_CNT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_TRAIL,
        ST_EOF
    } state_e;

    function automatic logic [31:0] make_trailer(input logic        trunc,
                                                 input logic [6:0]  ch,
                                                 input logic [15:0] cnt);
        logic [31:0] t;
        t                        = '0;
        t[TRL_MARK_LSB +: 8]     = TRL_MARK;
        t[TRL_TRUNC_BIT]         = trunc;
        t[TRL_CH_LSB +: 7]       = ch;
        t[TRL_CNT_LSB +: 16]     = cnt;
        return t;
    endfunction

endpackage

// File: rtl/xillybus_rd_fifo.sv
// Synchronous FIFO with standard (registered, latency-1) read port and a synchronous flush.
module xillybus_rd_fifo
    import xillybus_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = rd_data_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        do_wr     = wr_en && !full && !flush;
        do_rd     = rd_en && !empty && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_rd) begin
                rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
                rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // NOTE: state flops use non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/xillybus_rd_mux.sv
// Round-robin packet multiplexer onto one Xillybus read stream, with per-packet trailer and eof.
module xillybus_rd_mux
    import xillybus_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 32,
    parameter int FIFO_AW = 4,
    parameter int MAX_PKT = 1024
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_last,
    output logic [NCH-1:0]    ch_ready,
    input  logic              eof_req,
    input  logic              user_r_rden,
    output logic [DW-1:0]     user_r_data,
    output logic              user_r_empty,
    output logic              user_r_eof,
    input  logic              user_r_open,
    output logic [31:0]       drop_cnt
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] gnt_q, gnt_d, cand_gnt, idx;
    logic [15:0]   cnt_q, cnt_d;
    logic [16:0]   cnt_inc;
    logic          trunc_q, trunc_d;
    logic          eof_q, eof_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;
    logic          fifo_wr, fifo_full, fifo_empty, flush;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] data_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign data_arr[g] = ch_data[g*DW +: DW];
    end

    // Scan downward so the nearest valid channel after the last grant wins.
    always_comb begin
        cand_gnt = gnt_q;
        idx      = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = CW'((int'(gnt_q) + k) % NCH);
            if (ch_valid[idx]) cand_gnt = idx;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        trunc_d    = trunc_q;
        drop_cnt_d = drop_cnt_q;
        ch_ready   = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = data_arr[gnt_q];
        flush      = 1'b0;
        if (!user_r_open) begin
            // Host closed: swallow everything and forget any packet in flight.
            flush    = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = '0;
            ch_ready = '1;
            for (int i = 0; i < NCH; i++) drop_cnt_d = drop_cnt_d + {31'd0, ch_valid[i]};
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|ch_valid) begin
                        gnt_d   = cand_gnt;
                        state_d = ST_PASS;
                    end else if (eof_req && fifo_empty) begin
                        state_d = ST_EOF;
                    end
                end
                ST_PASS: begin
                    ch_ready[gnt_q] = !fifo_full;
                    if (ch_valid[gnt_q] && !fifo_full) begin
                        fifo_wr = 1'b1;
                        cnt_d   = cnt_inc[15:0];
                        if (ch_last[gnt_q] || cnt_inc == 17'(MAX_PKT)) begin
                            state_d = ST_TRAIL;
                            trunc_d = !ch_last[gnt_q];
                        end
                    end
                end
                ST_TRAIL: begin
                    if (!fifo_full) begin
                        fifo_wr    = 1'b1;
                        fifo_wdata = DW'(make_trailer(trunc_q, 7'(gnt_q), cnt_q));
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_EOF: begin
                    if (!eof_req) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        eof_d = (state_d == ST_EOF);
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= CW'(NCH - 1);
            cnt_q      <= '0;
            trunc_q    <= 1'b0;
            eof_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            trunc_q    <= trunc_d;
            eof_q      <= eof_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    xillybus_rd_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (bus_clk),
        .rst_n   (trn_reset_n),
        .flush   (flush),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (user_r_rden),
        .rd_data (user_r_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign user_r_empty = fifo_empty;
    assign user_r_eof   = eof_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_xillybus_rd_mux.sv
// Directed bench for xillybus_rd_mux: packet-level reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_xillybus_rd_mux;

    localparam int NCH     = 4;
    localparam int DW      = 32;
    localparam int FIFO_AW = 3;
    localparam int MAX_PKT = 4;

    logic              bus_clk = 1'b0;
    logic              trn_reset_n;
    logic [NCH*DW-1:0] ch_data  = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_last  = '0;
    logic [NCH-1:0]    ch_ready;
    logic              eof_req;
    logic              user_r_rden = 1'b0;
    logic [DW-1:0]     user_r_data;
    logic              user_r_empty;
    logic              user_r_eof;
    logic              user_r_open;
    logic [31:0]       drop_cnt;

    xillybus_rd_mux #(
        .NCH(NCH), .DW(DW), .FIFO_AW(FIFO_AW), .MAX_PKT(MAX_PKT)
    ) dut (
        .bus_clk      (bus_clk),
        .trn_reset_n  (trn_reset_n),
        .ch_data      (ch_data),
        .ch_valid     (ch_valid),
        .ch_last      (ch_last),
        .ch_ready     (ch_ready),
        .eof_req      (eof_req),
        .user_r_rden  (user_r_rden),
        .user_r_data  (user_r_data),
        .user_r_empty (user_r_empty),
        .user_r_eof   (user_r_eof),
        .user_r_open  (user_r_open),
        .drop_cnt     (drop_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [32:0] chq [NCH][$];
    logic [31:0] exp_q [$];
    logic [31:0] rd_log [$];
    logic        host_rd = 1'b0;
    logic [NCH-1:0] acc  = '0;
    logic        rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] trl(input int t, input int ch, input int cnt);
        return 32'hCE00_0000 + 32'(t << 23) + 32'(ch << 16) + 32'(cnt);
    endfunction

    // What the host must read for one packet: words cut into MAX_PKT chunks, each closed by a trailer.
    task automatic model_pkt(input int ch, input int n, input logic [31:0] base);
        int cnt = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(base + 32'(k));
            cnt++;
            if (k == n - 1) begin
                exp_q.push_back(trl(0, ch, cnt));
                cnt = 0;
            end else if (cnt == MAX_PKT) begin
                exp_q.push_back(trl(1, ch, cnt));
                cnt = 0;
            end
        end
    endtask

    task automatic send_pkt(input int ch, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) chq[ch].push_back({(k == n - 1), base + 32'(k)});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += chq[i].size();
        return s;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
            @(negedge bus_clk);
            n++;
        end
        check({name, "_drain"}, (exp_q.size() == 0 && pending() == 0), 1);
        repeat (3) @(negedge bus_clk);
        check({name, "_empty"}, user_r_empty, 1);
    endtask

    // Channel sources, host reader and the per-read compare against the model.
    always begin
        logic [32:0] w;
        @(negedge bus_clk);
        #1;
        if (rd_pend) begin
            check("rd_exp_avail", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rd_data", user_r_data, exp_q.pop_front());
            rd_log.push_back(user_r_data);
        end
        for (int i = 0; i < NCH; i++)
            if (acc[i] && chq[i].size() != 0) void'(chq[i].pop_front());
        for (int i = 0; i < NCH; i++) begin
            if (chq[i].size() != 0) begin
                w = chq[i][0];
                ch_valid[i]           = 1'b1;
                ch_last[i]            = w[32];
                ch_data[i*DW +: DW]   = w[31:0];
            end else begin
                ch_valid[i]           = 1'b0;
                ch_last[i]            = 1'b0;
                ch_data[i*DW +: DW]   = '0;
            end
        end
        user_r_rden = host_rd;
        #3;
        acc     = ch_valid & ch_ready;
        rd_pend = user_r_rden && !user_r_empty;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        trn_reset_n = 1'b0;
        user_r_open = 1'b1;
        eof_req     = 1'b0;
        repeat (3) @(negedge bus_clk);
        check("rst_ready", ch_ready, 4'b0000);
        check("rst_data", user_r_data, 32'h0);
        check("rst_empty", user_r_empty, 1);
        check("rst_eof", user_r_eof, 0);
        check("rst_drop", drop_cnt, 32'h0);
        trn_reset_n = 1'b1;
        repeat (2) @(negedge bus_clk);

        // Round robin: ch0 and ch2 contend with two packets each; pointer starts at 3 -> 0,2,0,2.
        host_rd = 1'b1;
        rd_log.delete();
        send_pkt(0, 2, 32'h0A00_0000); send_pkt(0, 2, 32'h0C00_0000);
        send_pkt(2, 2, 32'h2B00_0000); send_pkt(2, 2, 32'h2D00_0000);
        model_pkt(0, 2, 32'h0A00_0000); model_pkt(2, 2, 32'h2B00_0000);
        model_pkt(0, 2, 32'h0C00_0000); model_pkt(2, 2, 32'h2D00_0000);
        wait_drain("rr", 300);
        check("rr_t0", rd_log[2], 32'hCE00_0002);
        check("rr_first2", rd_log[3], 32'h2B00_0000);
        check("rr_t2", rd_log[5], 32'hCE02_0002);
        check("rr_second0", rd_log[6], 32'h0C00_0000);
        check("rr_t3", rd_log[11], 32'hCE02_0002);

        // Single 3-word packet on ch1.
        rd_log.delete();
        send_pkt(1, 3, 32'h1111_0000);
        model_pkt(1, 3, 32'h1111_0000);
        check("model_ch1_trl", exp_q[3], 32'hCE01_0003);
        wait_drain("ch1", 200);
        check("ch1_w0", rd_log[0], 32'h1111_0000);
        check("ch1_w2", rd_log[2], 32'h1111_0002);
        check("ch1_trl", rd_log[3], 32'hCE01_0003);
        check("ch1_hold", user_r_data, 32'hCE01_0003);

        // Forced end at MAX_PKT: 6 words on ch3 -> 4 + truncated trailer, 2 + normal trailer.
        rd_log.delete();
        send_pkt(3, 6, 32'h3333_0000);
        model_pkt(3, 6, 32'h3333_0000);
        check("model_ch3_t1", exp_q[4], 32'hCE83_0004);
        check("model_ch3_t2", exp_q[7], 32'hCE03_0002);
        wait_drain("ch3", 200);
        check("ch3_t1", rd_log[4], 32'hCE83_0004);
        check("ch3_w4", rd_log[5], 32'h3333_0004);
        check("ch3_t2", rd_log[7], 32'hCE03_0002);

        // Backpressure: host idle, depth 8 fills with 4 words + trailer + 3 words.
        host_rd = 1'b0;
        rd_log.delete();
        send_pkt(0, 12, 32'h4444_0000);
        model_pkt(0, 12, 32'h4444_0000);
        repeat (20) @(negedge bus_clk);
        check("full_ready", ch_ready, 4'b0000);
        check("full_left", chq[0].size(), 5);
        check("full_nonempty", user_r_empty, 0);
        host_rd = 1'b1;
        wait_drain("full", 300);
        check("full_count", rd_log.size(), 15);

        // Stream closed mid-packet for 5 cycles while ch0 keeps offering words.
        host_rd = 1'b0;
        rd_log.delete();
        chq[0].push_back({1'b0, 32'h5555_0000});
        n = 0;
        while (chq[0].size() != 0 && n < 20) begin
            @(negedge bus_clk);
            n++;
        end
        repeat (2) @(negedge bus_clk);
        check("open_pre_nonempty", user_r_empty, 0);
        for (int k = 0; k < 5; k++) chq[0].push_back({1'b0, 32'h5555_1000 + 32'(k)});
        user_r_open = 1'b0;
        repeat (5) @(negedge bus_clk);
        check("open_drop_cnt", drop_cnt, 32'd5);
        check("open_empty", user_r_empty, 1);
        user_r_open = 1'b1;
        host_rd     = 1'b1;
        send_pkt(0, 3, 32'h5555_2000);
        model_pkt(0, 3, 32'h5555_2000);
        wait_drain("reopen", 200);
        check("reopen_count", rd_log.size(), 4);
        check("reopen_trl", rd_log[3], 32'hCE00_0003);

        // End of file with idle channels; cleared by closing, and by dropping the request.
        eof_req = 1'b1;
        repeat (2) @(negedge bus_clk);
        check("eof_set", user_r_eof, 1);
        check("eof_no_grant", ch_ready, 4'b0000);
        user_r_open = 1'b0;
        @(negedge bus_clk);
        check("eof_clr_open", user_r_eof, 0);
        user_r_open = 1'b1;
        repeat (2) @(negedge bus_clk);
        check("eof_reset", user_r_eof, 1);
        eof_req = 1'b0;
        repeat (2) @(negedge bus_clk);
        check("eof_clr_req", user_r_eof, 0);

        // Asynchronous reset in the middle of a packet.
        host_rd = 1'b0;
        send_pkt(2, 3, 32'h6666_0000);
        repeat (3) @(negedge bus_clk);
        check("mid_pre_nonempty", user_r_empty, 0);
        #2;
        trn_reset_n = 1'b0;
        #1;
        check("mid_rst_ready", ch_ready, 4'b0000);
        check("mid_rst_data", user_r_data, 32'h0);
        check("mid_rst_empty", user_r_empty, 1);
        check("mid_rst_eof", user_r_eof, 0);
        check("mid_rst_drop", drop_cnt, 32'h0);
        for (int i = 0; i < NCH; i++) chq[i].delete();
        exp_q.delete();
        @(negedge bus_clk);
        trn_reset_n = 1'b1;
        repeat (2) @(negedge bus_clk);

        // Clean packet after reset.
        host_rd = 1'b1;
        rd_log.delete();
        send_pkt(1, 2, 32'h7777_0000);
        model_pkt(1, 2, 32'h7777_0000);
        wait_drain("post_rst", 200);
        check("post_rst_trl", rd_log[2], 32'hCE01_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
